// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sar_pkg
//  Purpose  : Shared types and constants for the SAR conversion controller:
//             FSM state encoding, counter widths and the default converter
//             geometry shared with the ADC top level.
//  Revision : 1.0  initial release
// ============================================================================
package sar_pkg;

    // Default converter geometry, shared with the ADC top level
    localparam int NBITS_DEF         = 8;
    localparam int SAMPLE_CYCLES_DEF = 2;

    // Legal parameter ranges
    localparam int NBITS_MAX         = 16;
    localparam int SAMPLE_CYCLES_MAX = 15;

    // Bit index holds 0..NBITS_MAX-1; sample counter holds 0..SAMPLE_CYCLES_MAX-1
    localparam int IDX_W  = $clog2(NBITS_MAX);
    localparam int SCNT_W = $clog2(SAMPLE_CYCLES_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sar_ctrl_if
//  Purpose  : Bundle of the SAR controller's conversion-side signals.
//             master : the controller (drives track/hold, DAC code, results)
//             slave  : the analog models / back-end around it
//  Options  : SAR_OVERRANGE_EN adds the ovr result flag.
//  Revision : 1.0  initial release
// ============================================================================
interface sar_ctrl_if
    import sar_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
);
    logic             start;
    logic             comp;
    logic             sample;
    logic             comp_en;
    logic [NBITS-1:0] dac_code;
    logic [NBITS-1:0] dout;
    logic             dout_valid;
    logic             busy;
`ifdef SAR_OVERRANGE_EN
    logic             ovr;
`endif

    modport master (
        input  start,
        input  comp,
        output sample,
        output comp_en,
        output dac_code,
        output dout,
        output dout_valid,
        output busy
`ifdef SAR_OVERRANGE_EN
        ,
        output ovr
`endif
    );

    modport slave (
        output start,
        output comp,
        input  sample,
        input  comp_en,
        input  dac_code,
        input  dout,
        input  dout_valid,
        input  busy
`ifdef SAR_OVERRANGE_EN
        ,
        input  ovr
`endif
    );

endinterface : sar_ctrl_if
`default_nettype wire

// File: rtl/sar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sar_ctrl
//  Purpose  : Synchronous successive-approximation controller. Tracks the
//             input for SAMPLE_CYCLES, then tests one DAC bit per cycle from
//             MSB to LSB, keeping each bit the comparator accepts, and
//             publishes the final code with a one-cycle valid pulse.
//  Options  : SAR_OVERRANGE_EN adds ovr, set when the result is all-ones or
//             all-zeros, registered alongside dout.
//  Revision : 1.0  initial release
// ============================================================================
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS         = NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sar_ctrl_if.master  bus
);

    sar_state_t        r_state;
    sar_state_t        w_state_nxt;
    logic [SCNT_W-1:0] r_scnt;
    logic [SCNT_W-1:0] w_scnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [NBITS-1:0]  r_dac;
    logic [NBITS-1:0]  w_dac_nxt;
    logic [NBITS-1:0]  r_dout;
    logic [NBITS-1:0]  w_dout_nxt;
    logic              w_result_load;

    // One-hot mask of the bit under trial and of the next bit down
    logic [NBITS-1:0]  w_trial_bit;
    logic [NBITS-1:0]  w_lower_bit;
    // Accumulated code with the trial bit resolved by the comparator
    logic [NBITS-1:0]  w_decided;

    assign w_trial_bit = {{(NBITS-1){1'b0}}, 1'b1} << r_idx;
    assign w_lower_bit = w_trial_bit >> 1;
    assign w_decided   = bus.comp ? r_dac : (r_dac & ~w_trial_bit);

    // Next-state and datapath update; the DAC register doubles as accumulator
    always_comb begin
        w_state_nxt   = r_state;
        w_scnt_nxt    = r_scnt;
        w_idx_nxt     = r_idx;
        w_dac_nxt     = r_dac;
        w_dout_nxt    = r_dout;
        w_result_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SAMPLE;
                    w_scnt_nxt  = SCNT_W'(SAMPLE_CYCLES - 1);
                    w_dac_nxt   = '0;
                end
            end
            SAMPLE: begin
                if (r_scnt == '0) begin
                    w_state_nxt = CONV;
                    w_idx_nxt   = IDX_W'(NBITS - 1);
                    w_dac_nxt   = {1'b1, {(NBITS-1){1'b0}}};
                end else begin
                    w_scnt_nxt  = r_scnt - 1'b1;
                end
            end
            CONV: begin
                if (r_idx == '0) begin
                    w_state_nxt   = DONE;
                    w_dac_nxt     = w_decided;
                    w_dout_nxt    = w_decided;
                    w_result_load = 1'b1;
                end else begin
                    w_dac_nxt     = w_decided | w_lower_bit;
                    w_idx_nxt     = r_idx - 1'b1;
                end
            end
            DONE: begin
                // Start seen here chains straight into the next sample phase
                w_dac_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = SAMPLE;
                    w_scnt_nxt  = SCNT_W'(SAMPLE_CYCLES - 1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_dac_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_idx   <= '0;
            r_dac   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dac   <= w_dac_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

`ifdef SAR_OVERRANGE_EN
    logic r_ovr;

    // Over-range flag captured with the result: code pinned at either rail
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_result_load) begin
            r_ovr <= (&w_decided) | ~(|w_decided);
        end
    end

    assign bus.ovr = r_ovr;
`endif

    // Control outputs are decodes of the registered state
    assign bus.sample     = (r_state == SAMPLE);
    assign bus.comp_en    = (r_state == CONV);
    assign bus.busy       = (r_state == SAMPLE) || (r_state == CONV);
    assign bus.dout_valid = (r_state == DONE);
    assign bus.dac_code   = r_dac;
    assign bus.dout       = r_dout;

endmodule : sar_ctrl
`default_nettype wire

// File: tb/tb_sar_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sar_ctrl
//  Purpose  : Self-checking bench for sar_ctrl. An ideal comparator model
//             (target >= dac_code) closes the loop; expected results are
//             queued when a start is driven and checked when dout_valid fires.
//             Instances: 8-bit / 2 sample cycles and 4-bit / 1 sample cycle.
//  Options  : SAR_OVERRANGE_EN also checks ovr.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sar_ctrl;
    import sar_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_ctrl_if #(.NBITS(8)) if8 ();
    sar_ctrl_if #(.NBITS(4)) if4 ();

    sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.master)
    );

    sar_ctrl #(.NBITS(4), .SAMPLE_CYCLES(1)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.master)
    );

    // Ideal comparator: keep the trial bit when the input is at or above it
    logic [7:0] target8;
    logic [3:0] target4;
    assign if8.comp = (target8 >= if8.dac_code);
    assign if4.comp = (target4 >= if4.dac_code);

    typedef struct {
        logic [7:0] dout;
        int         cyc;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] exp_dout;
        logic       exp_ovr;
    } vec_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle and score any completed result on either DUT
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (if8.dout_valid === 1'b1) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid8 cyc=%0d actual=1 required=0", cyc);
            end else begin
                e = q8.pop_front();
                chk("dout8", 32'(if8.dout), 32'(e.dout));
                chk("valid_cyc8", cyc, e.cyc);
                chk("busy_at_valid8", 32'(if8.busy), 32'd0);
`ifdef SAR_OVERRANGE_EN
                chk("ovr8", 32'(if8.ovr), 32'(e.ovr));
`endif
            end
        end
        if (if4.dout_valid === 1'b1) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid4 cyc=%0d actual=1 required=0", cyc);
            end else begin
                e = q4.pop_front();
                chk("dout4", 32'(if4.dout), 32'(e.dout));
                chk("valid_cyc4", cyc, e.cyc);
                chk("busy_at_valid4", 32'(if4.busy), 32'd0);
`ifdef SAR_OVERRANGE_EN
                chk("ovr4", 32'(if4.ovr), 32'(e.ovr));
`endif
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q8.size() > 0 || q4.size() > 0); i++) step();
        if (q8.size() > 0 || q4.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_valid cyc=%0d actual=%0d required=0 pending", cyc, q8.size() + q4.size());
            q8.delete();
            q4.delete();
        end
        step();
    endtask

    task automatic run8(input logic [7:0] tgt, input logic ovr);
        target8   = tgt;
        if8.start = 1'b1;
        q8.push_back('{dout: tgt, cyc: cyc + 11, ovr: ovr});
        step();
        if8.start = 1'b0;
        drain();
    endtask

    vec_t       vecs[7];
    logic [7:0] seq[8];
    int         c0;

    initial begin
        vecs[0] = '{tgt: 8'hA5, exp_dout: 8'hA5, exp_ovr: 1'b0};
        vecs[1] = '{tgt: 8'h00, exp_dout: 8'h00, exp_ovr: 1'b1};
        vecs[2] = '{tgt: 8'hFF, exp_dout: 8'hFF, exp_ovr: 1'b1};
        vecs[3] = '{tgt: 8'h01, exp_dout: 8'h01, exp_ovr: 1'b0};
        vecs[4] = '{tgt: 8'h80, exp_dout: 8'h80, exp_ovr: 1'b0};
        vecs[5] = '{tgt: 8'h7F, exp_dout: 8'h7F, exp_ovr: 1'b0};
        vecs[6] = '{tgt: 8'hFE, exp_dout: 8'hFE, exp_ovr: 1'b0};
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        rst       = 1'b1;
        if8.start = 1'b0;
        if4.start = 1'b0;
        target8   = 8'h00;
        target4   = 4'h0;

        // Reset held three cycles, then idle with start low
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 2) rst = 1'b0;
            chk("rst_sample", 32'(if8.sample), 32'd0);
            chk("rst_comp_en", 32'(if8.comp_en), 32'd0);
            chk("rst_busy", 32'(if8.busy), 32'd0);
            chk("rst_dac", 32'(if8.dac_code), 32'd0);
            chk("rst_dout", 32'(if8.dout), 32'd0);
            chk("rst_valid", 32'(if8.dout_valid), 32'd0);
`ifdef SAR_OVERRANGE_EN
            chk("rst_ovr", 32'(if8.ovr), 32'd0);
`endif
        end

        // Single conversion of A5 with cycle-by-cycle control checks
        target8   = 8'hA5;
        c0        = cyc;
        if8.start = 1'b1;
        q8.push_back('{dout: 8'hA5, cyc: c0 + 11, ovr: 1'b0});
        for (int k = 1; k <= 11; k++) begin
            step();
            if8.start = 1'b0;
            chk("a5_sample", 32'(if8.sample), (k <= 2) ? 32'd1 : 32'd0);
            chk("a5_comp_en", 32'(if8.comp_en), (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
            chk("a5_busy", 32'(if8.busy), (k <= 10) ? 32'd1 : 32'd0);
            if (k <= 2) chk("a5_dac_sample", 32'(if8.dac_code), 32'd0);
            else if (k <= 10) chk("a5_dac_trial", 32'(if8.dac_code), 32'(seq[k-3]));
            else chk("a5_dac_final", 32'(if8.dac_code), 32'hA5);
        end
        drain();

        // Table of single conversions
        for (int v = 0; v < 7; v++) begin
            target8   = vecs[v].tgt;
            if8.start = 1'b1;
            q8.push_back('{dout: vecs[v].exp_dout, cyc: cyc + 11, ovr: vecs[v].exp_ovr});
            step();
            if8.start = 1'b0;
            drain();
        end

        // Back-to-back with start held high: 00 then FF, 11 cycles apart
        target8   = 8'h00;
        c0        = cyc;
        if8.start = 1'b1;
        q8.push_back('{dout: 8'h00, cyc: c0 + 11, ovr: 1'b1});
        q8.push_back('{dout: 8'hFF, cyc: c0 + 22, ovr: 1'b1});
        while (cyc < c0 + 11) step();
        target8 = 8'hFF;
        step();
        chk("b2b_resample", 32'(if8.sample), 32'd1);
        chk("b2b_busy", 32'(if8.busy), 32'd1);
        while (cyc < c0 + 22 && q8.size() > 0) step();
        if8.start = 1'b0;
        step();
        chk("b2b_idle_sample", 32'(if8.sample), 32'd0);
        chk("b2b_idle_busy", 32'(if8.busy), 32'd0);
        drain();

        // Start pulsed again mid-conversion is ignored
        target8   = 8'h3C;
        c0        = cyc;
        if8.start = 1'b1;
        q8.push_back('{dout: 8'h3C, cyc: c0 + 11, ovr: 1'b0});
        step();
        if8.start = 1'b0;
        while (cyc < c0 + 5) step();
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        drain();
        for (int k = 0; k < 15; k++) step();

        // Reset mid-conversion aborts with no result
        target8   = 8'h77;
        c0        = cyc;
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        while (cyc < c0 + 6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_sample", 32'(if8.sample), 32'd0);
        chk("abort_comp_en", 32'(if8.comp_en), 32'd0);
        chk("abort_busy", 32'(if8.busy), 32'd0);
        chk("abort_dac", 32'(if8.dac_code), 32'd0);
        chk("abort_dout", 32'(if8.dout), 32'd0);
        for (int k = 0; k < 15; k++) step();
        run8(8'h77, 1'b0);

        // Narrow instance: 4 bits, 1 sample cycle, valid in cycle 6
        target4   = 4'h9;
        if4.start = 1'b1;
        q4.push_back('{dout: 8'h09, cyc: cyc + 6, ovr: 1'b0});
        step();
        if4.start = 1'b0;
        drain();
        target4   = 4'hF;
        if4.start = 1'b1;
        q4.push_back('{dout: 8'h0F, cyc: cyc + 6, ovr: 1'b1});
        step();
        if4.start = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sar_ctrl
`default_nettype wire
